// File: rtl/fetch_pkg.sv
// Shared state encoding and constants for the instruction fetch stage.
package fetch_pkg;
  typedef enum logic [2:0] {IDLE, REQ, WAIT, HOLD, FAULT} fetch_state_t;
  localparam logic [31:0] INSTR_NOP       = 32'h0000_0013;
  localparam logic [31:0] PC_STEP_DEFAULT = 32'd4;
endpackage

// File: rtl/instruction_fetch.sv
// Fetch stage: one outstanding imem request, valid/ready toward decode, redirect flush; FETCH_ALIGN_CHECK_EN adds FAULT.
// Min 3 cycles/instr (REQ, WAIT, HOLD); decoder backpressure holds the word in HOLD and stalls further requests.
module instruction_fetch
  import fetch_pkg::*;
#(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = PC_STEP_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  output logic [31:0] imem_req_addr,
  input  logic        imem_req_ready,
  input  logic        imem_rsp_valid,
  input  logic [31:0] imem_rsp_data,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_target,
`ifdef FETCH_ALIGN_CHECK_EN
  output logic        fetch_misaligned,
`endif
  output logic        instr_valid,
  output logic [31:0] instr,
  output logic [31:0] instr_pc,
  input  logic        instr_ready
);

  fetch_state_t r_state;
  logic [31:0]  r_pc;
  logic [31:0]  r_instr;
  logic [31:0]  r_instr_pc;
  logic         r_drop;
  logic         r_fault_pend;

  logic [31:0]  w_tgt;
  logic         w_mis;
  fetch_state_t w_redir_state;

`ifdef FETCH_ALIGN_CHECK_EN
  assign w_tgt            = redirect_target;
  assign w_mis            = |redirect_target[1:0];
  assign fetch_misaligned = (r_state == FAULT);
`else
  assign w_tgt            = redirect_target & 32'hFFFF_FFFC;
  assign w_mis            = 1'b0;
`endif

  // Where a redirect lands when no response is left outstanding.
  assign w_redir_state = w_mis ? FAULT : REQ;

  assign imem_req_valid = (r_state == REQ);
  assign imem_req_addr  = r_pc;
  assign instr_valid    = (r_state == HOLD);
  assign instr          = r_instr;
  assign instr_pc       = r_instr_pc;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= IDLE;
      r_pc         <= RESET_PC;
      r_drop       <= 1'b0;
      r_fault_pend <= 1'b0;
      r_instr      <= 32'h0;
      r_instr_pc   <= 32'h0;
    end else if (redirect_valid) begin
      r_pc <= w_tgt;
      case (r_state)
        REQ: begin
          if (imem_req_ready) begin
            r_state      <= WAIT;
            r_drop       <= 1'b1;
            r_fault_pend <= w_mis;
          end else begin
            r_state <= w_redir_state;
            if (w_mis) r_instr_pc <= w_tgt;
          end
        end
        WAIT: begin
          if (imem_rsp_valid) begin
            r_drop       <= 1'b0;
            r_fault_pend <= 1'b0;
            r_state      <= w_redir_state;
            if (w_mis) r_instr_pc <= w_tgt;
          end else begin
            r_drop       <= 1'b1;
            r_fault_pend <= w_mis;
          end
        end
        default: begin
          r_state <= w_redir_state;
          if (w_mis) r_instr_pc <= w_tgt;
        end
      endcase
    end else begin
      case (r_state)
        IDLE: r_state <= REQ;
        REQ:  if (imem_req_ready) r_state <= WAIT;
        WAIT: begin
          if (imem_rsp_valid) begin
            if (r_drop) begin
              // Stale word from before a redirect: drop it, then resume or fault.
              r_drop       <= 1'b0;
              r_fault_pend <= 1'b0;
              r_state      <= r_fault_pend ? FAULT : REQ;
              if (r_fault_pend) r_instr_pc <= r_pc;
            end else begin
              r_instr    <= imem_rsp_data;
              r_instr_pc <= r_pc;
              r_pc       <= r_pc + PC_STEP;
              r_state    <= HOLD;
            end
          end
        end
        HOLD:    if (instr_ready) r_state <= REQ;
        default: r_state <= r_state;
      endcase
    end
  end

endmodule

// File: tb/tb_instruction_fetch.sv
// Bench for instruction_fetch: directed scenarios plus randomized traffic against a flag-based reference model.
module tb_instruction_fetch;

  logic        clk;
  logic        reset;
  logic        imem_req_valid;
  logic [31:0] imem_req_addr;
  logic        imem_req_ready;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        redirect_valid;
  logic [31:0] redirect_target;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_ready;

  instruction_fetch dut (
    .clk             (clk),
    .reset           (reset),
    .imem_req_valid  (imem_req_valid),
    .imem_req_addr   (imem_req_addr),
    .imem_req_ready  (imem_req_ready),
    .imem_rsp_valid  (imem_rsp_valid),
    .imem_rsp_data   (imem_rsp_data),
    .redirect_valid  (redirect_valid),
    .redirect_target (redirect_target),
    .instr_valid     (instr_valid),
    .instr           (instr),
    .instr_pc        (instr_pc),
    .instr_ready     (instr_ready)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  bit cmp_en = 0;

  // Stimulus knobs
  logic        r_ready, r_iready, r_redir;
  logic [31:0] r_tgt;
  int          dly_lo, dly_hi;
  bit          spur_en;
  logic [1:0]  dly_pick;

  // Model: started = left the post-reset idle cycle, busy = request in flight,
  // drop = in-flight word is stale, hold = word offered to decoder.
  typedef struct packed {
    logic        started;
    logic        busy;
    logic        drop;
    logic        hold;
    logic [31:0] pc;
    logic [31:0] instr;
    logic [31:0] ipc;
    logic [1:0]  dly;
  } model_t;

  model_t m;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return a ^ 32'hC0DE_0013;
  endfunction

  function automatic model_t model_reset();
    model_t r;
    r = '0;
    return r;
  endfunction

  function automatic model_t step(input model_t s, input logic rst, input logic rdy,
                                  input logic rv, input logic [31:0] rd, input logic redir,
                                  input logic [31:0] tgt, input logic ir, input logic [1:0] pick);
    model_t n;
    logic   acc;
    logic   rsp;
    n   = s;
    acc = s.started && !s.busy && !s.hold && rdy;
    rsp = s.busy && rv;
    if (rst) begin
      n = model_reset();
    end else if (redir) begin
      n.started = 1'b1;
      n.pc      = tgt & 32'hFFFF_FFFC;
      if (s.hold) n.hold = 1'b0;
      else if (s.busy) begin
        if (rsp) begin n.busy = 1'b0; n.drop = 1'b0; end
        else begin n.drop = 1'b1; if (s.dly != 0) n.dly = s.dly - 2'd1; end
      end else if (acc) begin
        n.busy = 1'b1; n.drop = 1'b1; n.dly = pick;
      end
    end else if (!s.started) begin
      n.started = 1'b1;
    end else if (s.hold) begin
      if (ir) n.hold = 1'b0;
    end else if (s.busy) begin
      if (rsp) begin
        n.busy = 1'b0;
        if (s.drop) n.drop = 1'b0;
        else begin n.hold = 1'b1; n.instr = rd; n.ipc = s.pc; n.pc = s.pc + 32'd4; end
      end else if (s.dly != 0) n.dly = s.dly - 2'd1;
    end else if (acc) begin
      n.busy = 1'b1; n.dly = pick;
    end
    return n;
  endfunction

  always @(posedge clk)
    m <= step(m, reset, imem_req_ready, imem_rsp_valid, imem_rsp_data,
              redirect_valid, redirect_target, instr_ready, dly_pick);

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h, expected %h", nm, act, exp);
    end
  endtask

  always @(negedge clk) begin
    if (cmp_en && !reset) begin
      chk("cmp_req_valid", {31'b0, imem_req_valid}, {31'b0, m.started && !m.busy && !m.hold});
      chk("cmp_req_addr", imem_req_addr, m.pc);
      chk("cmp_instr_valid", {31'b0, instr_valid}, {31'b0, m.hold});
      chk("cmp_instr", instr, m.instr);
      chk("cmp_instr_pc", instr_pc, m.ipc);
    end
  end

  task automatic nxt();
    @(negedge clk);
  endtask

  task automatic drive();
    imem_req_ready  = r_ready;
    instr_ready     = r_iready;
    redirect_valid  = r_redir;
    redirect_target = r_tgt;
    dly_pick        = 2'($urandom_range(dly_hi, dly_lo));
    if (m.busy && m.dly == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(m.pc);
    end else if (!m.busy && spur_en && $urandom_range(3, 0) == 0) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = $urandom;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
  endtask

  task automatic wait_for(input bit want_instr, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 20; i++) begin
      nxt();
      if (want_instr ? instr_valid : imem_req_valid) begin
        ok = 1'b1;
        break;
      end
      drive();
    end
  endtask

  initial begin
    #300000;
    $display("FAIL watchdog: got no end of test, expected $finish");
    $fatal(1);
  end

  initial begin
    bit ok;
    int sel;
    reset = 1'b1;
    r_ready = 0; r_iready = 0; r_redir = 0; r_tgt = 0;
    dly_lo = 0; dly_hi = 0; spur_en = 0;
    imem_req_ready = 0; instr_ready = 0; redirect_valid = 0; redirect_target = 0;
    imem_rsp_valid = 0; imem_rsp_data = 0; dly_pick = 0;
    nxt(); nxt(); nxt();
    cmp_en = 1;
    chk("rst_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);
    chk("rst_req_addr", imem_req_addr, 32'd0);

    // Streaming at full rate: request, wait, hold.
    reset = 1'b0; r_ready = 1; r_iready = 1;
    drive();
    for (int k = 1; k <= 12; k++) begin
      nxt();
      chk("seq_req_valid", {31'b0, imem_req_valid}, {31'b0, (k % 3) == 1});
      if (k % 3 == 1) chk("seq_req_addr", imem_req_addr, 32'((k / 3) * 4));
      chk("seq_instr_valid", {31'b0, instr_valid}, {31'b0, (k % 3) == 0});
      if (k % 3 == 0) begin
        chk("seq_instr_pc", instr_pc, 32'(((k / 3) - 1) * 4));
        chk("seq_instr", instr, mem_word(32'(((k / 3) - 1) * 4)));
      end
      r_iready = (k < 12);
      drive();
    end

    // Decoder stall holds the word and blocks requests.
    for (int j = 0; j < 5; j++) begin
      nxt();
      chk("hold_instr_valid", {31'b0, instr_valid}, 32'd1);
      chk("hold_instr_pc", instr_pc, 32'h0000_000C);
      chk("hold_instr", instr, mem_word(32'h0000_000C));
      chk("hold_req_valid", {31'b0, imem_req_valid}, 32'd0);
      r_iready = (j == 4);
      drive();
    end
    nxt();
    chk("rel_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("rel_req_addr", imem_req_addr, 32'h0000_0010);
    dly_lo = 2; dly_hi = 2;
    drive();

    // Redirect while waiting; late response is dropped.
    nxt();
    chk("t3_wait_req_valid", {31'b0, imem_req_valid}, 32'd0);
    r_redir = 1; r_tgt = 32'h0000_0100;
    drive();
    r_redir = 0;
    wait_for(0, ok);
    chk("t3_req_seen", {31'b0, ok}, 32'd1);
    chk("t3_req_addr", imem_req_addr, 32'h0000_0100);
    drive();
    wait_for(1, ok);
    chk("t3_instr_seen", {31'b0, ok}, 32'd1);
    chk("t3_instr_pc", instr_pc, 32'h0000_0100);
    chk("t3_instr", instr, mem_word(32'h0000_0100));

    // Redirect coinciding with the response.
    dly_lo = 0; dly_hi = 0;
    drive();
    nxt();
    chk("t4_req_valid", {31'b0, imem_req_valid}, 32'd1);
    drive();
    nxt();
    r_redir = 1; r_tgt = 32'h0000_0200;
    drive();
    r_redir = 0;
    nxt();
    chk("t4_req_after", {31'b0, imem_req_valid}, 32'd1);
    chk("t4_req_addr", imem_req_addr, 32'h0000_0200);
    chk("t4_instr_valid", {31'b0, instr_valid}, 32'd0);
    drive();
    wait_for(1, ok);
    chk("t4_instr_pc", instr_pc, 32'h0000_0200);

    // Redirect in HOLD with instr_ready high: held word is not consumed.
    r_redir = 1; r_tgt = 32'h0000_0040;
    drive();
    r_redir = 0;
    nxt();
    chk("t5_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("t5_req_valid", {31'b0, imem_req_valid}, 32'd1);
    chk("t5_req_addr", imem_req_addr, 32'h0000_0040);
    drive();
    wait_for(1, ok);
    chk("t5_instr_pc", instr_pc, 32'h0000_0040);

    // PC wrap at the top of the address space.
    r_redir = 1; r_tgt = 32'hFFFF_FFFC;
    drive();
    r_redir = 0;
    nxt();
    chk("t6_req_addr", imem_req_addr, 32'hFFFF_FFFC);
    drive();
    wait_for(1, ok);
    chk("t6_instr_pc", instr_pc, 32'hFFFF_FFFC);
    drive();
    wait_for(0, ok);
    chk("t6_wrap_addr", imem_req_addr, 32'h0000_0000);

    // Misaligned target is aligned down; redirect also completes a REQ handshake.
    r_redir = 1; r_tgt = 32'h0000_0103;
    drive();
    r_redir = 0;
    wait_for(0, ok);
    chk("t7_req_addr", imem_req_addr, 32'h0000_0100);
    drive();

    // Asynchronous reset mid-fetch.
    nxt();
    drive();
    #1 reset = 1'b1;
    #1;
    chk("rst2_req_valid", {31'b0, imem_req_valid}, 32'd0);
    chk("rst2_instr_valid", {31'b0, instr_valid}, 32'd0);
    chk("rst2_req_addr", imem_req_addr, 32'd0);
    chk("rst2_instr_pc", instr_pc, 32'd0);
    nxt();
    reset = 1'b0; spur_en = 1;
    drive();
    wait_for(0, ok);
    chk("rst2_first_addr", imem_req_addr, 32'd0);
    drive();

    // Randomized traffic checked by the compare process.
    dly_lo = 0; dly_hi = 3;
    for (int c = 0; c < 3000; c++) begin
      nxt();
      if ($urandom_range(599, 0) == 0) begin
        #1 reset = 1'b1;
        nxt();
        reset = 1'b0;
      end
      r_ready  = ($urandom_range(3, 0) != 0);
      r_iready = ($urandom_range(2, 0) != 0);
      r_redir  = ($urandom_range(9, 0) == 0);
      sel = $urandom_range(2, 0);
      if (sel == 0)      r_tgt = $urandom;
      else if (sel == 1) r_tgt = 32'hFFFF_FFF0 | 32'($urandom_range(15, 0));
      else               r_tgt = 32'($urandom_range(255, 0));
      drive();
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/instruction_fetch.md
Name: instruction_fetch

Overview:
- Fetch stage directly upstream of the instruction decoder.
- Owns the PC and issues one instruction-memory request at a time.
- Captures the returned 32-bit word and presents it, with its PC, to the decoder over a valid/ready handshake.
- Accepts redirects (branch/jump targets) from execute and discards stale in-flight fetches.

Parameters:
RESET_PC, 32'h0000_0000, PC loaded on reset
PC_STEP, 4, PC increment per sequential fetch

Ports:
clk  input  1  clock, all state updates on rising edge
reset  input  1  asynchronous, active-high reset
imem_req_valid  output  1  fetch request valid
imem_req_addr  output  32  fetch address (current PC)
imem_req_ready  input  1  memory accepts request this cycle
imem_rsp_valid  input  1  response word valid
imem_rsp_data  input  32  response instruction word
redirect_valid  input  1  load new PC, flush stage
redirect_target  input  32  new PC
instr_valid  output  1  instr/instr_pc valid toward decoder
instr  output  32  fetched instruction word
instr_pc  output  32  PC of instr
instr_ready  input  1  decoder consumes instr this cycle

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (reset).
- Reset values: state=IDLE, pc=RESET_PC, drop=0, instr_valid=0, instr=0, instr_pc=0, imem_req_valid=0.
- imem_req_valid=1 only in REQ. imem_req_addr=pc in all states.
- instr_valid=1 only in HOLD. All outputs are registered or decoded from state; no combinational path from redirect_valid or imem_rsp_* to any output.
- IDLE: go to REQ next cycle.
- REQ: on imem_req_ready, go to WAIT.
- WAIT: on imem_rsp_valid:
  - drop=0: instr<=imem_rsp_data, instr_pc<=pc, pc<=pc+PC_STEP, go to HOLD.
  - drop=1: discard the word, drop<=0, go to REQ.
- HOLD: on instr_ready, go to REQ.
- Throughput: minimum 3 cycles per instruction (REQ, WAIT, HOLD), exactly one outstanding request.
- Redirect has priority in every state; pc<=redirect_target.
  - IDLE/REQ without handshake: stay in or go to REQ.
  - REQ with imem_req_ready in the same cycle: the handshake completes, drop<=1, go to WAIT.
  - WAIT: drop<=1. If imem_rsp_valid arrives in the same cycle, the word is discarded, drop<=0, go to REQ.
  - HOLD: the held instruction is discarded (instr_valid=0 next cycle), go to REQ. This applies even if instr_ready is high in the same cycle; the decoder must treat a redirect cycle as non-consuming.
  - Back-to-back redirects: last target wins; drop stays set.
- imem_rsp_valid outside WAIT is ignored.
- pc+PC_STEP wraps modulo 2^32 (32'hFFFF_FFFC -> 32'h0000_0000).
- Reset mid-operation: immediate return to reset values. An outstanding memory response after reset lands in IDLE/REQ and is ignored.

Optional Feature:
FETCH_ALIGN_CHECK_EN
- Defined:
  - Adds output fetch_misaligned (1 bit, reset 0) and state FAULT.
  - A redirect with redirect_target[1:0]!=2'b00 enters FAULT after any outstanding response is drained.
  - In FAULT: no requests, fetch_misaligned=1, instr_pc=faulting target, instr_valid=0.
  - Only an aligned redirect leaves FAULT (to REQ, fetch_misaligned<=0).
- Undefined: redirect_target[1:0] is forced to 2'b00 when loaded into pc; no extra port or state.

Decomposition:
- Package fetch_pkg holds:
  - typedef enum fetch_state_t {IDLE, REQ, WAIT, HOLD, FAULT}
  - localparam INSTR_NOP = 32'h0000_0013
  - default PC_STEP = 4
- Single module; no sub-module required. PC register and FSM live together because redirect priority couples them.

Test Plan:
- Reset, imem_req_ready=1, response 1 cycle after accept, instr_ready=1 -> requests at 0x0, 0x4, 0x8; instr=memory words with instr_pc 0x0/0x4/0x8; one instr_valid every 3 cycles.
- Hold instr_ready=0 for 5 cycles in HOLD -> instr/instr_pc stable, no new imem request; release -> next request at pc+4.
- Redirect to 0x100 while in WAIT, response arrives 2 cycles later -> response dropped, next request addr 0x100, first delivered instr_pc=0x100.
- Redirect to 0x200 in the same cycle as imem_rsp_valid -> word discarded, next request addr 0x200.
- Redirect to 0x40 while in HOLD with instr_ready=1 -> held instruction not consumed, instr_valid=0 next cycle, next request 0x40.
- Set pc via redirect to 0xFFFF_FFFC, complete fetch -> instr_pc=0xFFFF_FFFC, next request 0x0000_0000.
- With FETCH_ALIGN_CHECK_EN, redirect to 0x102 -> fetch_misaligned=1, instr_pc=0x102, no requests; then redirect to 0x104 -> fetch_misaligned=0, request 0x104.
